// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: owns the PC, picks the next-PC source, drives
// the IF/ID and ID/EX squash/enable controls, and tracks halt, stalls and retired fetches.
//
// state   | meaning
// --------+---------------------------------------------------
// S_BOOT  | one cycle after reset, PC holds RESET_PC
// S_RUN   | normal fetch, next-PC chosen by priority
// S_HALTED| halt word seen, fetch frozen until reset
module fetch_control #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int unsigned STALL_MAX  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_if_out_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic        o_if_id_write,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_halted,
  output logic        o_align_err,
  output logic        o_stall_err,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_t;

  localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [7:0]  r_stall_cnt;
  logic        r_halted;
  logic        r_stall_err;

  logic        w_run;
  logic        w_branch;
  logic        w_jump;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_halt;
  logic        w_stall;
  logic        w_accept;
  logic [7:0]  w_stall_cnt_next;

  // Branch beats jump beats halt beats stall; a branch means everything younger is wrong-path.
  assign w_run      = (r_state == S_RUN);
  assign w_branch   = w_run & i_branch_taken;
  assign w_jump     = w_run & i_jump & ~i_branch_taken;
  assign w_redirect = w_branch | w_jump;
  assign w_target   = w_branch ? i_branch_target : i_jump_target;
  assign w_halt     = w_run & ~w_redirect & (i_instr == HALT_INSTR);
  assign w_stall    = w_run & ~w_redirect & ~w_halt & i_stall;
  assign w_accept   = w_run & ~w_redirect & ~w_halt & ~i_stall;

  assign w_stall_cnt_next = !w_stall              ? 8'd0 :
                            (r_stall_cnt == 8'hFF) ? 8'hFF :
                                                     r_stall_cnt + 8'd1;

  assign o_if_id_write = w_accept | w_redirect;
  assign o_flush_if_id = ~w_run | w_redirect | w_halt;
  assign o_flush_id_ex = w_branch;
  assign o_align_err   = w_redirect & (w_target[1:0] != 2'b00);

  assign o_pc          = r_pc;
  assign o_halted      = r_halted;
  assign o_stall_err   = r_stall_err;
  assign o_fetch_count = r_fetch_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'd0;
      r_stall_cnt   <= 8'd0;
      r_halted      <= 1'b0;
      r_stall_err   <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_next;
      if (w_stall_cnt_next >= STALL_LIMIT) r_stall_err <= 1'b1;
      case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
          if (w_redirect) begin
            r_pc <= {w_target[31:2], 2'b00};
          end else if (w_halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else if (w_accept) begin
            r_pc          <= i_if_out_pc;
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed literal sequences plus randomized traffic,
// all checked against a transaction-level model of the fetch sequencer.
module tb_fetch_control;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          SMAX = 3;

  localparam int W_IDLE = 0, W_BR = 1, W_JMP = 2, W_HALT = 3, W_STALL = 4, W_FETCH = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, bt = 1'b0, jmp = 1'b0;
  logic [31:0] btg = 32'd0, jtg = 32'd0, instr = 32'd0;
  logic [31:0] if_out_pc;
  logic [31:0] pc, fetch_count;
  logic        if_id_write, flush_if_id, flush_id_ex, halted, align_err, stall_err;

  assign if_out_pc = pc + 32'd4;

  fetch_control #(.RESET_PC(32'h0), .HALT_INSTR(HALT), .STALL_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_taken(bt),
    .i_branch_target(btg), .i_jump(jmp), .i_jump_target(jtg),
    .i_if_out_pc(if_out_pc), .i_instr(instr), .o_pc(pc),
    .o_if_id_write(if_id_write), .o_flush_if_id(flush_if_id),
    .o_flush_id_ex(flush_id_ex), .o_halted(halted), .o_align_err(align_err),
    .o_stall_err(stall_err), .o_fetch_count(fetch_count)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = boot cycle, 1 = running, 2 = halted
  int          m_phase = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_count = 32'd0;
  int          m_consec = 0;
  logic        m_err = 1'b0, m_halted = 1'b0, m_valid = 1'b0;

  task automatic model_reset();
    m_phase = 0; m_pc = 32'd0; m_count = 32'd0; m_consec = 0;
    m_err = 1'b0; m_halted = 1'b0;
  endtask

  function automatic int winner();
    if (rst || m_phase != 1) return W_IDLE;
    if (bt)                  return W_BR;
    if (jmp)                 return W_JMP;
    if (instr == HALT)       return W_HALT;
    if (stall)               return W_STALL;
    return W_FETCH;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [31:0] tgt;
    if (rst) begin model_reset(); m_valid = 1'b1; end
    if (m_valid) begin
      w   = winner();
      tgt = (w == W_BR) ? btg : jtg;
      chk("pc", pc, m_pc);
      chk("fetch_count", fetch_count, m_count);
      chk("halted", halted, m_halted);
      chk("stall_err", stall_err, m_err);
      chk("if_id_write", if_id_write, (w == W_BR || w == W_JMP || w == W_FETCH));
      chk("flush_if_id", flush_if_id, (w == W_IDLE || w == W_BR || w == W_JMP || w == W_HALT));
      chk("flush_id_ex", flush_id_ex, (w == W_BR));
      chk("align_err", align_err, ((w == W_BR || w == W_JMP) && tgt[1:0] != 2'b00));
      if (!rst) begin
        if (w == W_STALL) m_consec = (m_consec < 255) ? m_consec + 1 : 255;
        else              m_consec = 0;
        if (m_consec >= SMAX) m_err = 1'b1;
        case (w)
          W_BR, W_JMP: m_pc = tgt & 32'hFFFF_FFFC;
          W_HALT:      begin m_phase = 2; m_halted = 1'b1; end
          W_FETCH:     begin m_pc = m_pc + 32'd4; m_count = m_count + 32'd1; end
          default:     ;
        endcase
        if (m_phase == 0) m_phase = 1;
      end
    end
  end

  task automatic go(input logic st, input logic b, input logic [31:0] bg,
                    input logic j, input logic [31:0] jg, input logic [31:0] ins);
    @(posedge clk); #1;
    stall = st; bt = b; btg = bg; jmp = j; jtg = jg; instr = ins;
    @(negedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("lit_boot_pc", pc, 32'h0);
    chk("lit_boot_ifidw", if_id_write, 1'b0);
    chk("lit_boot_flush", flush_if_id, 1'b1);
    go(0, 0, 0, 0, 0, 0);  chk("lit_pc_b", pc, 32'h0); chk("lit_ifidw_b", if_id_write, 1'b1);
    go(0, 0, 0, 0, 0, 0);  chk("lit_pc_c", pc, 32'h4);
    go(1, 0, 0, 0, 0, 0);  chk("lit_pc_d", pc, 32'h8); chk("lit_stall_ifidw", if_id_write, 1'b0);
    go(1, 0, 0, 0, 0, 0);  chk("lit_pc_e", pc, 32'h8);
    go(1, 0, 0, 0, 0, 0);  chk("lit_pc_f", pc, 32'h8); chk("lit_err_f", stall_err, 1'b0);
    go(0, 0, 0, 0, 0, 0);  chk("lit_pc_g", pc, 32'h8); chk("lit_err_g", stall_err, 1'b1);
    go(0, 0, 0, 0, 0, 0);  chk("lit_pc_h", pc, 32'hC); chk("lit_count_h", fetch_count, 32'd3);
    go(0, 0, 0, 0, 0, 0);  chk("lit_pc_i", pc, 32'h10);
    go(1, 0, 0, 1, 32'h40, 0);
    chk("lit_jmp_flush", flush_if_id, 1'b1); chk("lit_jmp_flushex", flush_id_ex, 1'b0);
    go(0, 0, 0, 0, 0, 0);  chk("lit_pc_jmp", pc, 32'h40);
    go(0, 1, 32'h102, 1, 32'h80, 0);
    chk("lit_br_flushex", flush_id_ex, 1'b1); chk("lit_br_align", align_err, 1'b1);
    go(0, 0, 0, 0, 0, HALT); chk("lit_pc_br", pc, 32'h100); chk("lit_halt_ifidw", if_id_write, 1'b0);
    go(0, 1, 32'h203, 0, 0, HALT);
    chk("lit_halted", halted, 1'b1); chk("lit_halt_pc", pc, 32'h100);
    chk("lit_halt_count", fetch_count, 32'd6); chk("lit_halt_align", align_err, 1'b0);
    go(0, 0, 0, 0, 0, 0);  chk("lit_halt_pc2", pc, 32'h100);
    @(posedge clk); #1 rst = 1'b1; #2;
    chk("lit_async_pc", pc, 32'h0); chk("lit_async_halted", halted, 1'b0);
    chk("lit_async_count", fetch_count, 32'd0);

    // wrap of the retired-fetch counter
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    #1 release dut.r_fetch_count;
    @(negedge clk); #1;
    go(0, 0, 0, 0, 0, 0);  chk("lit_wrap", fetch_count, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 2) == 0);
      bt    = ($urandom_range(0, 7) == 0);
      jmp   = ($urandom_range(0, 6) == 0);
      btg   = $urandom;
      jtg   = $urandom;
      instr = ($urandom_range(0, 24) == 0) ? HALT : $urandom;
    end
    @(posedge clk); #1 rst = 1'b0; stall = 1'b0; bt = 1'b0; jmp = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
